// File: rtl/sextium_mem_pkg.sv
// Shared types and constants for the sextium memory arbiter.
package sextium_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StAck
  } state_e;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_B   = 1'b1;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/sextium_sp_ram.sv
// Single-port synchronous RAM with registered read output and per-lane write enables.
module sextium_sp_ram #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int NUM_LANES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_en,
  input  logic                 i_we,
  input  logic [NUM_LANES-1:0] i_be,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  output logic [DATA_W-1:0]    o_rdata
);

  localparam int LANE_W = DATA_W / NUM_LANES;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Contents are never reset; read returns the pre-write value on a write cycle.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (i_be[l]) begin
            r_mem[i_addr][l*LANE_W +: LANE_W] <= i_wdata[l*LANE_W +: LANE_W];
          end
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sextium_mem_arbiter.sv
// Two-master round-robin arbiter onto one single-port RAM with configurable wait states.
// Optional lane write enables are compiled in with SEXTIUM_MEM_BYTEENA_EN.
module sextium_mem_arbiter
  import sextium_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic [DATA_W-1:0] mem_bus_out,
  output logic [DATA_W-1:0] mem_bus_in,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_ack,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              b_read,
  input  logic              b_write,
  output logic              b_ack
`ifdef SEXTIUM_MEM_BYTEENA_EN
  ,
  input  logic [DATA_W/8-1:0] mem_byteena,
  input  logic [DATA_W/8-1:0] b_byteena
`endif
);

`ifdef SEXTIUM_MEM_BYTEENA_EN
  localparam int NUM_LANES = DATA_W / 8;
`else
  localparam int NUM_LANES = 1;
`endif

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_e                r_state, w_state_next;
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_next;
  logic                  r_last, r_gnt, r_wr;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [NUM_LANES-1:0]  r_be;
  logic                  r_mem_ack, r_b_ack;
  logic [DATA_W-1:0]     r_mem_bus_in, r_b_rdata;

  logic                  w_cpu_req, w_b_req, w_grant, w_pick;
  logic [NUM_LANES-1:0]  w_pick_be;
  logic [DATA_W-1:0]     w_ram_rdata;

  assign w_cpu_req = mem_read | mem_write;
  assign w_b_req   = b_read | b_write;
  assign w_grant   = (r_state == StIdle) && (w_cpu_req || w_b_req);

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    w_pick = MASTER_CPU;
    if (w_cpu_req && w_b_req) begin
      w_pick = (r_last == MASTER_B) ? MASTER_CPU : MASTER_B;
    end else if (w_b_req) begin
      w_pick = MASTER_B;
    end
  end

`ifdef SEXTIUM_MEM_BYTEENA_EN
  assign w_pick_be = (w_pick == MASTER_B) ? b_byteena : mem_byteena;
`else
  assign w_pick_be = '1;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_state_next = (WAIT_STATES > 0) ? StWait : StAccess;
          w_cnt_next   = WAIT_LOAD;
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_state_next = StAccess;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StAccess: w_state_next = StAck;
      StAck:    w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_last       <= MASTER_B;
      r_gnt        <= MASTER_CPU;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_mem_ack    <= 1'b0;
      r_b_ack      <= 1'b0;
      r_mem_bus_in <= '0;
      r_b_rdata    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_mem_ack <= (r_state == StAccess) && (r_gnt == MASTER_CPU);
      r_b_ack   <= (r_state == StAccess) && (r_gnt == MASTER_B);
      if (w_grant) begin
        r_gnt   <= w_pick;
        r_last  <= w_pick;
        r_be    <= w_pick_be;
        // Write wins when a port raises both read and write.
        r_wr    <= (w_pick == MASTER_B) ? b_write : mem_write;
        r_addr  <= (w_pick == MASTER_B) ? b_addr : addr_bus;
        r_wdata <= (w_pick == MASTER_B) ? b_wdata : mem_bus_out;
      end
      if ((r_state == StAck) && !r_wr) begin
        if (r_gnt == MASTER_B) begin
          r_b_rdata <= w_ram_rdata;
        end else begin
          r_mem_bus_in <= w_ram_rdata;
        end
      end
    end
  end

  sextium_sp_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_LANES(NUM_LANES)
  ) u_ram (
    .i_clk  (clock),
    .i_en   (r_state == StAccess),
    .i_we   ((r_state == StAccess) && r_wr),
    .i_be   (r_be),
    .i_addr (r_addr),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_rdata)
  );

  assign mem_ack    = r_mem_ack;
  assign b_ack      = r_b_ack;
  assign mem_bus_in = r_mem_bus_in;
  assign b_rdata    = r_b_rdata;

endmodule

// File: tb/tb_sextium_mem_arbiter.sv
// Directed bench: instance 0 has no wait states, instance 1 has three.
module tb_sextium_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst     [2];
  logic [AW-1:0] c_addr  [2];
  logic [AW-1:0] b_addr  [2];
  logic [DW-1:0] c_wdata [2];
  logic [DW-1:0] b_wdata [2];
  logic [DW-1:0] c_rdata [2];
  logic [DW-1:0] b_rdata [2];
  logic          c_rd    [2];
  logic          c_wr    [2];
  logic          c_ack   [2];
  logic          b_rd    [2];
  logic          b_wr    [2];
  logic          b_ack   [2];
`ifdef SEXTIUM_MEM_BYTEENA_EN
  logic [DW/8-1:0] c_be [2];
  logic [DW/8-1:0] b_be [2];
`endif

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sextium_mem_arbiter #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .WAIT_STATES(3 * g)
    ) u_dut (
      .clock      (clock),
      .reset      (rst[g]),
      .addr_bus   (c_addr[g]),
      .mem_bus_out(c_wdata[g]),
      .mem_bus_in (c_rdata[g]),
      .mem_read   (c_rd[g]),
      .mem_write  (c_wr[g]),
      .mem_ack    (c_ack[g]),
      .b_addr     (b_addr[g]),
      .b_wdata    (b_wdata[g]),
      .b_rdata    (b_rdata[g]),
      .b_read     (b_rd[g]),
      .b_write    (b_wr[g]),
      .b_ack      (b_ack[g])
`ifdef SEXTIUM_MEM_BYTEENA_EN
      ,
      .mem_byteena(c_be[g]),
      .b_byteena  (b_be[g])
`endif
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start offsets cs/bs are in cycles from now (-1 = port idle). Latencies are measured from
  // each port's own request cycle; *_glitch counts read-data changes before that port's ack.
  task automatic run(input int d,
                     input int cs, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                     input int bs, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bwd,
                     output int ct, output int bt, output int c_glitch, output int b_glitch);
    logic [DW-1:0] c_hold;
    logic [DW-1:0] b_hold;
    int acks_after;
    c_hold   = c_rdata[d];
    b_hold   = b_rdata[d];
    ct       = (cs < 0) ? 0 : -1;
    bt       = (bs < 0) ? 0 : -1;
    c_glitch = 0;
    b_glitch = 0;
    for (int i = 0; i < 48 && (ct < 0 || bt < 0); i++) begin
      if (i == cs) begin
        c_addr[d] = ca; c_wdata[d] = cwd; c_wr[d] = cw; c_rd[d] = !cw;
      end
      if (i == bs) begin
        b_addr[d] = ba; b_wdata[d] = bwd; b_wr[d] = bw; b_rd[d] = !bw;
      end
      @(negedge clock);
      if (ct < 0 && c_rdata[d] !== c_hold) c_glitch++;
      if (bt < 0 && b_rdata[d] !== b_hold) b_glitch++;
      if (ct < 0 && cs >= 0 && i >= cs && c_ack[d] === 1'b1) begin
        ct = i + 1 - cs; c_rd[d] = 1'b0; c_wr[d] = 1'b0;
      end
      if (bt < 0 && bs >= 0 && i >= bs && b_ack[d] === 1'b1) begin
        bt = i + 1 - bs; b_rd[d] = 1'b0; b_wr[d] = 1'b0;
      end
    end
    c_rd[d] = 1'b0; c_wr[d] = 1'b0; b_rd[d] = 1'b0; b_wr[d] = 1'b0;
    @(negedge clock);
    acks_after = int'(c_ack[d]) + int'(b_ack[d]);
    check_eq("ack one cycle", acks_after, 0);
  endtask

  int ct, bt, cg, bg, acks;
  logic [AW-1:0] wrap_addr;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      c_addr[d] = '0; c_wdata[d] = '0; c_rd[d] = 1'b0; c_wr[d] = 1'b0;
      b_addr[d] = '0; b_wdata[d] = '0; b_rd[d] = 1'b0; b_wr[d] = 1'b0;
`ifdef SEXTIUM_MEM_BYTEENA_EN
      c_be[d] = '1; b_be[d] = '1;
`endif
    end
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check_eq("reset mem_ack", c_ack[d], 0);
      check_eq("reset b_ack", b_ack[d], 0);
      check_eq("reset mem_bus_in", c_rdata[d], 0);
      check_eq("reset b_rdata", b_rdata[d], 0);
      rst[d] = 1'b0;
    end
    @(negedge clock);

    // No wait states: CPU write then read
    run(0, 0, 1, 12'h010, 16'hBEEF, -1, 0, '0, '0, ct, bt, cg, bg);
    check_eq("ws0 cpu wr lat", ct, 2);
    run(0, 0, 0, 12'h010, 16'h0000, -1, 0, '0, '0, ct, bt, cg, bg);
    check_eq("ws0 cpu rd lat", ct, 2);
    check_eq("ws0 cpu rd data", c_rdata[0], 16'hBEEF);
    run(0, -1, 0, '0, '0, 0, 1, 12'h020, 16'h0102, ct, bt, cg, bg);
    check_eq("ws0 b wr lat", bt, 2);
    check_eq("b write leaves b_rdata", b_rdata[0], 0);

    // Fresh reset: last grant is B, so CPU wins the first tie; RAM survives reset
    rst[0] = 1'b1;
    @(negedge clock);
    check_eq("rst clears mem_bus_in", c_rdata[0], 0);
    rst[0] = 1'b0;
    @(negedge clock);
    run(0, 0, 0, 12'h010, '0, 0, 0, 12'h020, '0, ct, bt, cg, bg);
    check_eq("tie1 cpu lat", ct, 2);
    check_eq("tie1 b lat", bt, 5);
    check_eq("tie1 cpu data", c_rdata[0], 16'hBEEF);
    check_eq("tie1 b data", b_rdata[0], 16'h0102);
    check_eq("tie1 b held", bg, 0);

    // CPU solo leaves last grant on CPU, so B wins the next tie
    run(0, 0, 0, 12'h020, '0, -1, 0, '0, '0, ct, bt, cg, bg);
    check_eq("cpu rd 020", c_rdata[0], 16'h0102);
    run(0, 0, 0, 12'h010, '0, 0, 0, 12'h010, '0, ct, bt, cg, bg);
    check_eq("tie2 b lat", bt, 2);
    check_eq("tie2 cpu lat", ct, 5);
    check_eq("tie2 cpu untouched by b rd", cg, 0);
    check_eq("tie2 cpu data", c_rdata[0], 16'hBEEF);
    check_eq("tie2 b data", b_rdata[0], 16'hBEEF);

    // B read arriving during a CPU write waits, keeps old b_rdata
    run(0, 0, 1, 12'h030, 16'h7777, 1, 0, 12'h020, '0, ct, bt, cg, bg);
    check_eq("hold cpu lat", ct, 2);
    check_eq("hold b lat", bt, 4);
    check_eq("hold b_rdata stable", bg, 0);
    check_eq("hold b data", b_rdata[0], 16'h0102);
    check_eq("hold mem_bus_in", c_rdata[0], 16'hBEEF);
    run(0, 0, 0, 12'h030, '0, -1, 0, '0, '0, ct, bt, cg, bg);
    check_eq("cpu rd 030", c_rdata[0], 16'h7777);

    // Three wait states on instance 1
    run(1, -1, 0, '0, '0, 0, 1, 12'hFFF, 16'h1234, ct, bt, cg, bg);
    check_eq("ws3 b wr lat", bt, 5);
    run(1, -1, 0, '0, '0, 0, 0, 12'hFFF, '0, ct, bt, cg, bg);
    check_eq("ws3 b rd lat", bt, 5);
    check_eq("ws3 b rd data", b_rdata[1], 16'h1234);
    wrap_addr = 12'hFFF;
    wrap_addr = wrap_addr + 1'b1;
    run(1, -1, 0, '0, '0, 0, 1, wrap_addr, 16'h00AB, ct, bt, cg, bg);
    run(1, -1, 0, '0, '0, 0, 0, 12'h000, '0, ct, bt, cg, bg);
    check_eq("wrap data", b_rdata[1], 16'h00AB);
    run(1, -1, 0, '0, '0, 0, 0, 12'hFFF, '0, ct, bt, cg, bg);
    check_eq("fff intact", b_rdata[1], 16'h1234);
    check_eq("ws3 mem_bus_in untouched", c_rdata[1], 0);

    // Reset during WAIT aborts the write
    run(1, 0, 1, 12'h040, 16'hAAAA, -1, 0, '0, '0, ct, bt, cg, bg);
    check_eq("ws3 cpu wr lat", ct, 5);
    c_addr[1] = 12'h040; c_wdata[1] = 16'h5555; c_wr[1] = 1'b1;
    repeat (2) @(negedge clock);
    rst[1] = 1'b1;
    c_wr[1] = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      acks += int'(c_ack[1]) + int'(b_ack[1]);
    end
    check_eq("mid rst no ack", acks, 0);
    check_eq("mid rst b_rdata", b_rdata[1], 0);
    rst[1] = 1'b0;
    @(negedge clock);
    run(1, 0, 0, 12'h040, '0, -1, 0, '0, '0, ct, bt, cg, bg);
    check_eq("post rst rd lat", ct, 5);
    check_eq("aborted write", c_rdata[1], 16'hAAAA);

`ifdef SEXTIUM_MEM_BYTEENA_EN
    run(0, 0, 1, 12'h050, 16'hFFFF, -1, 0, '0, '0, ct, bt, cg, bg);
    c_be[0] = 2'b01;
    run(0, 0, 1, 12'h050, 16'h0000, -1, 0, '0, '0, ct, bt, cg, bg);
    c_be[0] = 2'b00;
    run(0, 0, 1, 12'h050, 16'h1234, -1, 0, '0, '0, ct, bt, cg, bg);
    check_eq("be zero ack lat", ct, 2);
    c_be[0] = 2'b00;
    run(0, 0, 0, 12'h050, '0, -1, 0, '0, '0, ct, bt, cg, bg);
    check_eq("be lane data", c_rdata[0], 16'hFF00);
    c_be[0] = '1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
